// File: rtl/tse_evt_irq.sv
// ---------------------------------------------------------------------------
// tse_evt_irq
//
// Event capture and interrupt block for the TSE MAC, host clock domain.
// The synchronizer bank delivers event levels (link, autoneg, PHY and FIFO
// flags) that are already in the hclk domain. This block:
//   - turns level changes into sticky STATUS bits (rising edge only, or any
//     change for bits selected by BOTH_EDGE),
//   - masks them per bit,
//   - raises one coalesced, registered interrupt toward the AHB host, with an
//     optional holdoff delay before the interrupt asserts.
//
// Optional feature macro: CORETSE_IRQ_HOLDOFF_EN
//   defined     : HOLD state, holdoff counter and HOLDOFF register are present.
//   not defined : no HOLD state and no counter. HOLDOFF reads 0 and writes to
//                 it are ignored. IDLE goes straight to ASSERT.
//
// Parameters
//   NUM_EVT    number of event inputs (1..16)
//   BOTH_EDGE  per bit: 1 = any level change sets STATUS, 0 = rising edge only
//   HOLDOFF_W  width of the holdoff counter and of the HOLDOFF register (1..16)
//
// Ports
//   hclk       in   host clock
//   hresetn    in   asynchronous active-low reset
//   evt_lvl    in   [NUM_EVT] synchronized event levels
//   reg_sel    in   [2]  0 STATUS (W1C), 1 MASK, 2 LEVEL (RO), 3 HOLDOFF
//   reg_wr     in   write strobe, one cycle
//   reg_rd     in   read strobe, one cycle
//   reg_wdata  in   [16] write data
//   reg_rdata  out  [16] registered read data; holds until the next read
//   irq        out  interrupt request, registered, active-high
//   fsm_state  out  [2]  current interrupt FSM state (0 IDLE, 1 HOLD, 2 ASSERT)
//
// Register port handshake: there is no valid/ready pair on this port.
// reg_wr and reg_rd are single-cycle strobes that are always accepted in the
// cycle they are high. A read returns its data on reg_rdata one cycle later,
// and that value holds until the next read. A read and a write in the same
// cycle return the value from before the write.
// ---------------------------------------------------------------------------
module tse_evt_irq #(
  parameter int          NUM_EVT   = 16,
  parameter logic [15:0] BOTH_EDGE = 16'h0000,
  parameter int          HOLDOFF_W = 8
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NUM_EVT-1:0] evt_lvl,
  input  logic [1:0]         reg_sel,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [15:0]        reg_wdata,
  output logic [15:0]        reg_rdata,
  output logic               irq,
  output logic [1:0]         fsm_state
);

  // Register map
  localparam logic [1:0] SEL_STATUS  = 2'd0;
  localparam logic [1:0] SEL_MASK    = 2'd1;
  localparam logic [1:0] SEL_LEVEL   = 2'd2;
  localparam logic [1:0] SEL_HOLDOFF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_ASSERT = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [NUM_EVT-1:0] evt_prev_q;
  logic [NUM_EVT-1:0] status_q, status_d;
  logic [NUM_EVT-1:0] mask_q, mask_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               irq_q;
  state_t             state_q;

`ifdef CORETSE_IRQ_HOLDOFF_EN
  logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
  logic [HOLDOFF_W-1:0] cnt_q;
`endif

  // -------------------------------------------------------------------------
  // Write decode
  // -------------------------------------------------------------------------
  logic wr_status;
  logic wr_mask;

  assign wr_status = reg_wr && (reg_sel == SEL_STATUS);
  assign wr_mask   = reg_wr && (reg_sel == SEL_MASK);

  // -------------------------------------------------------------------------
  // Edge detection
  // evt_prev_q resets to 0, so an input that is already high when reset is
  // released sees a rising edge in the first cycle and sets its STATUS bit.
  // -------------------------------------------------------------------------
  logic [NUM_EVT-1:0] both_sel;
  logic [NUM_EVT-1:0] evt_edge;

  assign both_sel = BOTH_EDGE[NUM_EVT-1:0];
  assign evt_edge = (both_sel  & (evt_lvl ^ evt_prev_q)) |
                    (~both_sel & evt_lvl & ~evt_prev_q);

  // -------------------------------------------------------------------------
  // STATUS (W1C) and MASK next state
  // An edge on a bit wins over a clear of that bit in the same cycle, so an
  // event that lands exactly on the host's clear is not lost.
  // -------------------------------------------------------------------------
  logic [NUM_EVT-1:0] clr_bits;

  always_comb begin
    clr_bits = '0;
    if (wr_status) begin
      clr_bits = reg_wdata[NUM_EVT-1:0];
    end
    status_d = (status_q & ~clr_bits) | evt_edge;
  end

  always_comb begin
    mask_d = mask_q;
    if (wr_mask) begin
      mask_d = reg_wdata[NUM_EVT-1:0];
    end
  end

`ifdef CORETSE_IRQ_HOLDOFF_EN
  // A write to HOLDOFF only changes the reload value; a count already running
  // in HOLD keeps going from its own copy in cnt_q.
  always_comb begin
    holdoff_d = holdoff_q;
    if (reg_wr && (reg_sel == SEL_HOLDOFF)) begin
      holdoff_d = reg_wdata[HOLDOFF_W-1:0];
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Read mux. Bits above NUM_EVT (or above HOLDOFF_W) read as 0.
  // The mux samples the registers before this cycle's write lands, so a read
  // and a write in the same cycle return the old value.
  // -------------------------------------------------------------------------
  logic [15:0] status_ext;
  logic [15:0] mask_ext;
  logic [15:0] level_ext;
  logic [15:0] holdoff_ext;

  assign status_ext = 16'(status_q);
  assign mask_ext   = 16'(mask_q);
  assign level_ext  = 16'(evt_lvl);
`ifdef CORETSE_IRQ_HOLDOFF_EN
  assign holdoff_ext = 16'(holdoff_q);
`else
  assign holdoff_ext = 16'h0000;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (reg_rd) begin
      case (reg_sel)
        SEL_STATUS:  rdata_d = status_ext;
        SEL_MASK:    rdata_d = mask_ext;
        SEL_LEVEL:   rdata_d = level_ext;
        SEL_HOLDOFF: rdata_d = holdoff_ext;
        default:     rdata_d = 16'h0000;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      evt_prev_q <= '0;
      status_q   <= '0;
      mask_q     <= '0;
      rdata_q    <= 16'h0000;
    end else begin
      evt_prev_q <= evt_lvl;
      status_q   <= status_d;
      mask_q     <= mask_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef CORETSE_IRQ_HOLDOFF_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      holdoff_q <= '0;
    end else begin
      holdoff_q <= holdoff_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Interrupt FSM
  // pending is taken from the registered STATUS and MASK, so an event sets
  // STATUS on one edge and the FSM reacts on the next.
  // irq_q is loaded with "next state is ASSERT" on every transition, which
  // makes it high exactly while state_q is ASSERT.
  // -------------------------------------------------------------------------
  logic pending;

  assign pending = |(status_q & mask_q);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
`ifdef CORETSE_IRQ_HOLDOFF_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending) begin
`ifdef CORETSE_IRQ_HOLDOFF_EN
            if (holdoff_q == '0) begin
              state_q <= ST_ASSERT;
              irq_q   <= 1'b1;
            end else begin
              state_q <= ST_HOLD;
              cnt_q   <= holdoff_q;
              irq_q   <= 1'b0;
            end
`else
            state_q <= ST_ASSERT;
            irq_q   <= 1'b1;
`endif
          end else begin
            irq_q <= 1'b0;
          end
        end

`ifdef CORETSE_IRQ_HOLDOFF_EN
        // New events while counting do not reload the count.
        ST_HOLD: begin
          if (!pending) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end else if (cnt_q == HOLDOFF_W'(1)) begin
            state_q <= ST_ASSERT;
            irq_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - HOLDOFF_W'(1);
            irq_q <= 1'b0;
          end
        end
`endif

        ST_ASSERT: begin
          if (!pending) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end else begin
            irq_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign reg_rdata = rdata_q;
  assign irq       = irq_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_tse_evt_irq.sv
// ---------------------------------------------------------------------------
// tb_tse_evt_irq
//
// Self-checking bench for tse_evt_irq. Bit 5 is configured as both-edge,
// all other bits rising-edge only. Expected interrupt timing follows the
// holdoff build selected by CORETSE_IRQ_HOLDOFF_EN.
// Inputs are driven right after a falling edge; outputs are sampled at the
// following falling edge, half a cycle after the rising edge that updates
// them.
// ---------------------------------------------------------------------------
module tb_tse_evt_irq;

`ifdef CORETSE_IRQ_HOLDOFF_EN
  localparam bit HOLDOFF_EN = 1'b1;
`else
  localparam bit HOLDOFF_EN = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [15:0] evt_lvl = 16'h0000;
  logic [1:0]  reg_sel = 2'd0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [15:0] reg_wdata = 16'h0000;
  logic [15:0] reg_rdata;
  logic        irq;
  logic [1:0]  fsm_state;

  always #5 hclk = ~hclk;

  tse_evt_irq #(
    .NUM_EVT   (16),
    .BOTH_EDGE (16'h0020),
    .HOLDOFF_W (8)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .evt_lvl   (evt_lvl),
    .reg_sel   (reg_sel),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq),
    .fsm_state (fsm_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [15:0] exp_q[$];
  string       nm_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic chk_irq(input string name, input logic exp);
    chk(name, {15'd0, irq}, {15'd0, exp});
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (called just after a falling edge; return just after the
  // next falling edge)
  // -------------------------------------------------------------------------
  task automatic wr(input logic [1:0] sel, input logic [15:0] data);
    reg_sel   = sel;
    reg_wdata = data;
    reg_wr    = 1'b1;
    @(negedge hclk);
    reg_wr    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [15:0] exp, input string name);
    logic [15:0] e;
    string       n;
    reg_sel = sel;
    reg_rd  = 1'b1;
    exp_q.push_back(exp);
    nm_q.push_back(name);
    @(negedge hclk);
    reg_rd = 1'b0;
    e = exp_q.pop_front();
    n = nm_q.pop_front();
    chk(n, reg_rdata, e);
  endtask

  // -------------------------------------------------------------------------
  // Register vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic        is_wr;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [15:0] exp_rd;
    logic        exp_irq;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic is_wr, input logic [1:0] sel, input logic [15:0] data,
                              input logic [15:0] exp_rd, input logic exp_irq, input string name);
    vec_t v;
    v.is_wr   = is_wr;
    v.sel     = sel;
    v.data    = data;
    v.exp_rd  = exp_rd;
    v.exp_irq = exp_irq;
    v.name    = name;
    return v;
  endfunction

  vec_t vecs[14];

  // Watchdog: the sequence is fixed-length, this only guards against a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [15:0] ho_exp;
    int          lat;

    ho_exp = HOLDOFF_EN ? 16'h00AB : 16'h0000;
    lat    = HOLDOFF_EN ? 5 : 1;

    vecs[0]  = mk(1'b0, 2'd0, 16'h0000, 16'h0001, 1'b0, "rd_status_init");
    vecs[1]  = mk(1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, "rd_mask_init");
    vecs[2]  = mk(1'b0, 2'd2, 16'h0000, 16'h0001, 1'b0, "rd_level_init");
    vecs[3]  = mk(1'b0, 2'd3, 16'h0000, 16'h0000, 1'b0, "rd_holdoff_init");
    vecs[4]  = mk(1'b1, 2'd1, 16'hA5A4, 16'h0000, 1'b0, "wr_mask");
    vecs[5]  = mk(1'b0, 2'd1, 16'h0000, 16'hA5A4, 1'b0, "rd_mask");
    vecs[6]  = mk(1'b1, 2'd2, 16'hFFFF, 16'h0000, 1'b0, "wr_level");
    vecs[7]  = mk(1'b0, 2'd2, 16'h0000, 16'h0001, 1'b0, "rd_level_ro");
    vecs[8]  = mk(1'b1, 2'd3, 16'h01AB, 16'h0000, 1'b0, "wr_holdoff");
    vecs[9]  = mk(1'b0, 2'd3, 16'h0000, ho_exp,   1'b0, "rd_holdoff");
    vecs[10] = mk(1'b1, 2'd0, 16'h0001, 16'h0000, 1'b0, "w1c_bit0");
    vecs[11] = mk(1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, "rd_status_clr");
    vecs[12] = mk(1'b1, 2'd3, 16'h0000, 16'h0000, 1'b0, "wr_holdoff0");
    vecs[13] = mk(1'b1, 2'd1, 16'h0000, 16'h0000, 1'b0, "wr_mask0");

    // Reset with bit 0 high from release
    evt_lvl = 16'h0001;
    repeat (3) @(negedge hclk);
    chk_irq("rst_irq", 1'b0);
    chk("rst_rdata", reg_rdata, 16'h0000);
    chk("rst_state", {14'd0, fsm_state}, 16'd0);
    hresetn = 1'b1;
    @(negedge hclk);

    // Table-driven register accesses
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].sel, vecs[i].data);
      end else begin
        rd(vecs[i].sel, vecs[i].exp_rd, vecs[i].name);
      end
      chk_irq({vecs[i].name, "_irq"}, vecs[i].exp_irq);
    end

    // Read data holds until the next read
    rd(2'd2, 16'h0001, "rd_level_hold");
    repeat (2) @(negedge hclk);
    chk("rdata_hold", reg_rdata, 16'h0001);

    // Read and write in the same cycle return the pre-write value
    reg_sel   = 2'd1;
    reg_wdata = 16'h1234;
    reg_wr    = 1'b1;
    reg_rd    = 1'b1;
    @(negedge hclk);
    reg_wr = 1'b0;
    reg_rd = 1'b0;
    chk("rd_wr_same", reg_rdata, 16'h0000);
    rd(2'd1, 16'h1234, "rd_mask_after");
    wr(2'd1, 16'h0000);

    // Basic irq assert / W1C deassert with HOLDOFF=0
    wr(2'd1, 16'h0004);
    evt_lvl = 16'h0005;
    @(negedge hclk);
    chk_irq("b2_edge_k", 1'b0);
    @(negedge hclk);
    chk_irq("b2_edge_k1", 1'b1);
    chk("b2_state", {14'd0, fsm_state}, 16'd2);
    wr(2'd0, 16'h0004);
    chk_irq("b2_w1c_n", 1'b1);
    @(negedge hclk);
    chk_irq("b2_w1c_n1", 1'b0);
    wr(2'd1, 16'h0000);

    // Both-edge bit 5 vs rising-only bit 6
    evt_lvl = 16'h0025;
    @(negedge hclk);
    rd(2'd0, 16'h0020, "b5_rise");
    wr(2'd0, 16'h0020);
    evt_lvl = 16'h0005;
    @(negedge hclk);
    rd(2'd0, 16'h0020, "b5_fall");
    wr(2'd0, 16'h0020);
    evt_lvl = 16'h0045;
    @(negedge hclk);
    rd(2'd0, 16'h0040, "b6_rise");
    wr(2'd0, 16'h0040);
    evt_lvl = 16'h0005;
    @(negedge hclk);
    rd(2'd0, 16'h0000, "b6_fall");

    // Holdoff latency
    wr(2'd3, 16'h0004);
    wr(2'd1, 16'hFFFF);
    evt_lvl = 16'h0085;
    for (int j = 0; j <= 6; j++) begin
      @(negedge hclk);
      chk_irq($sformatf("ho_lat_k%0d", j), (j >= lat));
      if (j == 1) begin
        chk("ho_state", {14'd0, fsm_state}, HOLDOFF_EN ? 16'd1 : 16'd2);
      end
    end
    wr(2'd0, 16'h0080);
    chk_irq("ho_w1c_n", 1'b1);
    @(negedge hclk);
    chk_irq("ho_w1c_n1", 1'b0);

    // W1C while holding off: irq never asserts (holdoff build)
    evt_lvl = 16'h0185;
    @(negedge hclk);
    chk_irq("hc_k", 1'b0);
    @(negedge hclk);
    chk_irq("hc_k1", !HOLDOFF_EN);
    wr(2'd0, 16'h0100);
    chk_irq("hc_k2", !HOLDOFF_EN);
    for (int j = 0; j < 6; j++) begin
      @(negedge hclk);
      chk_irq($sformatf("hc_quiet%0d", j), 1'b0);
    end
    chk("hc_state", {14'd0, fsm_state}, 16'd0);
    wr(2'd3, 16'h0000);

    // Edge and W1C on bit 3 in the same cycle: set wins
    evt_lvl = 16'h018D;
    wr(2'd0, 16'h0008);
    chk_irq("sw_k", 1'b0);
    rd(2'd0, 16'h0008, "sw_status");
    chk_irq("sw_k1", 1'b1);

    // Async reset while irq is high
    @(negedge hclk);
    chk_irq("ar_pre", 1'b1);
    hresetn = 1'b0;
    evt_lvl = 16'h0000;
    #1;
    chk_irq("ar_irq", 1'b0);
    chk("ar_state", {14'd0, fsm_state}, 16'd0);
    chk("ar_rdata", reg_rdata, 16'h0000);
    @(negedge hclk);
    hresetn = 1'b1;
    rd(2'd0, 16'h0000, "ar_status");
    rd(2'd1, 16'h0000, "ar_mask");
    for (int j = 0; j < 4; j++) begin
      @(negedge hclk);
      chk_irq($sformatf("ar_quiet%0d", j), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
